// File: rtl/hwag_cfg_sched_if.sv
// rtl/hwag_cfg_sched_if.sv - host register bus between the SPI slave and the HWAG config scheduler
interface hwag_cfg_sched_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [23:0] rd_data;
  logic        rd_vld;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  wr_ack, wr_err, rd_data, rd_vld
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output wr_ack, wr_err, rd_data, rd_vld
  );
endinterface

// File: rtl/hwag_cfg_sched.sv
// rtl/hwag_cfg_sched.sv - staging bank for HWAG tunables with atomic commit on sync wrap
module hwag_cfg_sched #(
  parameter int                   TMO_WIDTH = 24,
  parameter logic [TMO_WIDTH-1:0] TMO_MAX   = 24'd5592405
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  hwag_cfg_sched_if.slave      host,
  input  logic                 i_commit_req,
  input  logic                 i_hwag_start,
  input  logic                 i_sync_pt,
  output logic [3:0]           o_cfg_stwd,
  output logic [23:0]          o_cfg_maxacr,
  output logic [23:0]          o_cfg_ld14,
  output logic [23:0]          o_cfg_ld23,
  output logic [23:0]          o_cfg_dwell_k,
  output logic [2:0]           o_cfg_ctrl,
  output logic                 o_cfg_upd,
  output logic                 o_busy
);
  localparam logic [3:0]  RST_STWD   = 4'd4;
  localparam logic [23:0] RST_MAXACR = 24'd3839;
  localparam logic [23:0] RST_LD14   = 24'd2752;
  localparam logic [23:0] RST_LD23   = 24'd832;
  localparam logic [23:0] RST_DWELL  = 24'd50000;
  localparam logic [2:0]  RST_CTRL   = 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SYNC, S_APPLY} state_t;

  state_t               r_state, w_next;
  logic [TMO_WIDTH-1:0] r_wdog;
  logic [3:0]           r_stg_stwd, r_act_stwd;
  logic [23:0]          r_stg_maxacr, r_stg_ld14, r_stg_ld23, r_stg_dwell;
  logic [23:0]          r_act_maxacr, r_act_ld14, r_act_ld23, r_act_dwell;
  logic [2:0]           r_stg_ctrl, r_act_ctrl;
  logic                 r_wr_ack, r_wr_err, r_rd_vld, r_upd;
  logic [23:0]          r_rd_data;
  logic                 r_cfg_err, r_tmo, r_clr_err, r_clr_tmo;
  logic                 w_busy, w_valid, w_apply_ok, w_apply_err, w_tmo_hit;

  assign w_busy      = (r_state != S_IDLE);
  assign w_valid     = (r_stg_stwd <= 4'd8) && (r_stg_maxacr != 24'd0) &&
                       (r_stg_ld14 <= r_stg_maxacr) && (r_stg_ld23 <= r_stg_maxacr);
  assign w_apply_ok  = (r_state == S_APPLY) && w_valid;
  assign w_apply_err = (r_state == S_APPLY) && !w_valid;

  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_commit_req) w_next = i_hwag_start ? S_WAIT_SYNC : S_APPLY;
      S_WAIT_SYNC:
        if (i_sync_pt || !i_hwag_start) begin
          w_next = S_APPLY;
        end else if (r_wdog == TMO_MAX) begin
          w_tmo_hit = 1'b1;
          w_next    = S_IDLE;
        end
      S_APPLY:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Watchdog is held at zero outside WAIT_SYNC so every wait starts from a cleared count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_wdog  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT_SYNC) r_wdog <= r_wdog + 1'b1;
      else                        r_wdog <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stg_stwd   <= RST_STWD;
      r_stg_maxacr <= RST_MAXACR;
      r_stg_ld14   <= RST_LD14;
      r_stg_ld23   <= RST_LD23;
      r_stg_dwell  <= RST_DWELL;
      r_stg_ctrl   <= RST_CTRL;
      r_wr_ack     <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_data    <= '0;
      r_cfg_err    <= 1'b0;
      r_tmo        <= 1'b0;
      r_clr_err    <= 1'b0;
      r_clr_tmo    <= 1'b0;
    end else begin
      r_wr_ack <= host.wr_en;
      r_wr_err <= host.wr_en & w_busy;
      if (host.wr_en && !w_busy) begin
        case (host.wr_addr)
          3'd0:    r_stg_stwd   <= host.wr_data[3:0];
          3'd1:    r_stg_maxacr <= host.wr_data;
          3'd2:    r_stg_ld14   <= host.wr_data;
          3'd3:    r_stg_ld23   <= host.wr_data;
          3'd4:    r_stg_dwell  <= host.wr_data;
          3'd5:    r_stg_ctrl   <= host.wr_data[2:0];
          default: ;
        endcase
      end

      r_rd_vld  <= host.rd_en;
      r_clr_err <= 1'b0;
      r_clr_tmo <= 1'b0;
      if (host.rd_en) begin
        case (host.rd_addr)
          3'd0:    r_rd_data <= {20'd0, r_stg_stwd};
          3'd1:    r_rd_data <= r_stg_maxacr;
          3'd2:    r_rd_data <= r_stg_ld14;
          3'd3:    r_rd_data <= r_stg_ld23;
          3'd4:    r_rd_data <= r_stg_dwell;
          3'd5:    r_rd_data <= {21'd0, r_stg_ctrl};
          3'd6: begin
            r_rd_data <= {20'd0, i_hwag_start, r_tmo, r_cfg_err, w_busy};
            // Only flags actually reported are cleared, so a late event is never lost unread.
            r_clr_err <= r_cfg_err;
            r_clr_tmo <= r_tmo;
          end
          default: r_rd_data <= '0;
        endcase
      end

      if (w_apply_err)    r_cfg_err <= 1'b1;
      else if (r_clr_err) r_cfg_err <= 1'b0;
      if (w_tmo_hit)      r_tmo <= 1'b1;
      else if (r_clr_tmo) r_tmo <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_act_stwd   <= RST_STWD;
      r_act_maxacr <= RST_MAXACR;
      r_act_ld14   <= RST_LD14;
      r_act_ld23   <= RST_LD23;
      r_act_dwell  <= RST_DWELL;
      r_act_ctrl   <= RST_CTRL;
      r_upd        <= 1'b0;
    end else begin
      r_upd <= w_apply_ok;
      if (w_apply_ok) begin
        r_act_stwd   <= r_stg_stwd;
        r_act_maxacr <= r_stg_maxacr;
        r_act_ld14   <= r_stg_ld14;
        r_act_ld23   <= r_stg_ld23;
        r_act_dwell  <= r_stg_dwell;
        r_act_ctrl   <= r_stg_ctrl;
      end
    end
  end

  assign host.wr_ack   = r_wr_ack;
  assign host.wr_err   = r_wr_err;
  assign host.rd_data  = r_rd_data;
  assign host.rd_vld   = r_rd_vld;
  assign o_cfg_stwd    = r_act_stwd;
  assign o_cfg_maxacr  = r_act_maxacr;
  assign o_cfg_ld14    = r_act_ld14;
  assign o_cfg_ld23    = r_act_ld23;
  assign o_cfg_dwell_k = r_act_dwell;
  assign o_cfg_ctrl    = r_act_ctrl;
  assign o_cfg_upd     = r_upd;
  assign o_busy        = w_busy;
endmodule

// File: doc/hwag_cfg_sched.md
# hwag_cfg_sched

Configuration and commit controller for the hardware angle generator (HWAG). It holds a host-writable staging register bank for the HWAG tunables: step-width shift, max angle count, coil-channel phase loads, dwell dividend and enables. It commits the whole bank atomically to the live outputs. The commit happens immediately while the HWAG is unsynchronised, or exactly on the angle-counter wrap strobe while it is running, so the angle datapath never sees a torn configuration mid-revolution. It sits between the SPI slave and the HWAG core.

## Interface
- TMO_WIDTH, 24: width of the sync-wait watchdog counter.
- TMO_MAX, 24'd5592405: cycles allowed in WAIT_SYNC before the commit is abandoned.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  host write strobe, one cycle.
- wr_addr  in  3  staging register address.
- wr_data  in  24  write data, LSB-aligned.
- wr_ack  out  1  write accepted, pulse.
- wr_err  out  1  write rejected, pulse coincident with wr_ack.
- rd_en  in  1  host read strobe.
- rd_addr  in  3  read address.
- rd_data  out  24  read data.
- rd_vld  out  1  rd_data valid, pulse.
- commit_req  in  1  request commit of staging to active, pulse.
- hwag_start  in  1  HWAG synchronised flag.
- sync_pt  in  1  angle-counter top strobe, one cycle per revolution.
- cfg_stwd  out  4  active step-width shift.
- cfg_maxacr  out  24  active max angle count.
- cfg_ld14  out  24  active coil14 counter load.
- cfg_ld23  out  24  active coil23 counter load.
- cfg_dwell_k  out  24  active dwell dividend.
- cfg_ctrl  out  3  active enables: bit0 engine, bit1 coil14, bit2 coil23.
- cfg_upd  out  1  pulse on the cycle the active set changes.
- busy  out  1  FSM not in IDLE.

## Operation
- Address map:
  - 0 STWD[3:0]
  - 1 MAXACR
  - 2 LD14
  - 3 LD23
  - 4 DWELL_K
  - 5 CTRL[2:0]
  - 6 STATUS, read-only: bit0 busy, bit1 cfg_err, bit2 tmo, bit3 hwag_start
  - 7 reserved: reads 0, writes ignored but acked
- Unused upper bits of narrow registers: write-ignored, read 0. Reads of 0–5 return staging, not active, values.
- Reset values, for both staging and active: STWD=4, MAXACR=3839, LD14=2752, LD23=832, DWELL_K=50000, CTRL=0.
- Other outputs at reset: cfg_upd=0, wr_ack=0, wr_err=0, rd_vld=0, rd_data=0, busy=0, cfg_err=0, tmo=0. FSM in IDLE.
- FSM states:
  - IDLE: on commit_req, go to APPLY if hwag_start=0, otherwise to WAIT_SYNC with the watchdog cleared.
  - WAIT_SYNC: go to APPLY on sync_pt, or when hwag_start drops to 0. If the watchdog reaches TMO_MAX, set tmo and go to IDLE with no commit.
  - APPLY: one cycle. Validate staging. If valid, copy all six staging registers to active and pulse cfg_upd. Otherwise set cfg_err and leave active unchanged. Then go to IDLE.
- Valid staging means STWD ≤ 8, MAXACR ≠ 0, LD14 ≤ MAXACR and LD23 ≤ MAXACR.
- Writes while busy=1 are rejected: wr_ack=1, wr_err=1, staging unchanged. This guarantees the snapshot taken in APPLY.
- commit_req while busy=1 is ignored.
- cfg_err and tmo are sticky. A read of STATUS clears them on the cycle after rd_vld, and rd_data shows the pre-clear value. An APPLY setting cfg_err on the same cycle as the clear wins.

## Timing
- Write: wr_en at cycle N → staging updated at edge N+1, wr_ack (and wr_err) high during N+1.
- Read: rd_en at N → rd_data/rd_vld valid during N+1. rd_data holds until the next read.
- Read and write to the same address in the same cycle: the read returns the old value.
- Write and commit_req in the same cycle from IDLE: the write is accepted and included in the commit, because APPLY samples staging no earlier than N+1.
- Unsynchronised commit: commit_req at N → APPLY at N+1 → active outputs and cfg_upd at N+2.
- Synchronised commit: sync_pt at cycle S while in WAIT_SYNC → APPLY at S+1 → active outputs and cfg_upd at S+2.
- sync_pt on the same cycle commit_req is taken from IDLE is not counted; the FSM waits for the next sync_pt.
- Watchdog increments each WAIT_SYNC cycle. It abandons the commit on the cycle its count equals TMO_MAX, with tmo visible next cycle.
- rst asserted mid-commit: immediate return to IDLE with all registers at reset values. No cfg_upd.

## Test plan
- Reset, then read addresses 0–5 → 4, 3839, 2752, 832, 50000, 0; STATUS=0; cfg_upd never pulsed.
- hwag_start=0: write MAXACR=1919, commit_req → active cfg_maxacr=1919 two cycles later, single cfg_upd pulse, busy low after.
- hwag_start=1: write LD14=100, commit_req, sync_pt 40 cycles later → cfg_ld14 unchanged until sync_pt+2, then 100. A write during the wait returns wr_err=1 and is not applied.
- Stage STWD=9 and commit → no cfg_upd, active STWD stays 4, STATUS bit1=1. A second STATUS read returns bit1=0.
- hwag_start=1, commit_req, no sync_pt, TMO_MAX set to 16 → busy drops after 16 cycles, tmo=1, actives unchanged.
- hwag_start falls during WAIT_SYNC → commit applied within 2 cycles. Assert rst during WAIT_SYNC → all outputs at reset values, busy=0.
